// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load/clear, shift, rotate and arithmetic shift,
// with multi-step commands executed one bit per cycle under a valid/ready handshake.
module universal_shift_register #(
    parameter int                 WIDTH       = 8,
    parameter int                 CW          = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CW-1:0]    cmd_count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] q,
    output logic             serial_out_msb,
    output logic             serial_out_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [2:0]       op_r;
    logic [CW-1:0]    remaining_r;
    logic [WIDTH-1:0] q_r;
    logic             busy_r;
    logic             done_r;

    // One single-bit step of a shift/rotate opcode; non-step opcodes hold the value.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] val,
        input logic             sil,
        input logic             sir
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_SHL:  res = {val[WIDTH-2:0], sil};
            OP_SHR:  res = {sir, val[WIDTH-1:1]};
            OP_ROL:  res = {val[WIDTH-2:0], val[WIDTH-1]};
            OP_ROR:  res = {val[0], val[WIDTH-1:1]};
            OP_ASR:  res = {val[WIDTH-1], val[WIDTH-1:1]};
            default: res = val;
        endcase
        return res;
    endfunction

    // Command acceptance, per-step execution and completion pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            op_r        <= OP_NOP;
            remaining_r <= {CW{1'b0}};
            q_r         <= RESET_VALUE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_NOP: begin
                                done_r <= 1'b1;
                            end
                            OP_LOAD: begin
                                q_r    <= load_data;
                                done_r <= 1'b1;
                            end
                            OP_CLEAR: begin
                                q_r    <= {WIDTH{1'b0}};
                                done_r <= 1'b1;
                            end
                            default: begin
                                // Shift/rotate: the first step lands on the acceptance edge.
                                if (cmd_count == {CW{1'b0}}) begin
                                    done_r <= 1'b1;
                                end else begin
                                    q_r         <= step_fn(cmd_op, q_r, serial_in_left, serial_in_right);
                                    remaining_r <= cmd_count - CW'(1);
                                    op_r        <= cmd_op;
                                    if (cmd_count == CW'(1)) begin
                                        done_r <= 1'b1;
                                    end else begin
                                        state_r <= RUN;
                                        busy_r  <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                RUN: begin
                    q_r <= step_fn(op_r, q_r, serial_in_left, serial_in_right);
                    if (remaining_r == CW'(1)) begin
                        remaining_r <= {CW{1'b0}};
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                    end else begin
                        remaining_r <= remaining_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready      = ~busy_r;
    assign q              = q_r;
    assign serial_out_msb = q_r[WIDTH-1];
    assign serial_out_lsb = q_r[0];
    assign busy           = busy_r;
    assign done           = done_r;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed scoreboard bench for universal_shift_register (WIDTH=8, CW=4).
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CW-1:0]    cmd_count;
    logic [WIDTH-1:0] load_data;
    logic             serial_in_left;
    logic             serial_in_right;
    logic [WIDTH-1:0] q;
    logic             serial_out_msb;
    logic             serial_out_lsb;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    universal_shift_register #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_count       (cmd_count),
        .load_data       (load_data),
        .serial_in_left  (serial_in_left),
        .serial_in_right (serial_in_right),
        .q               (q),
        .serial_out_msb  (serial_out_msb),
        .serial_out_lsb  (serial_out_lsb),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] op, input logic [CW-1:0] cnt,
                         input logic [WIDTH-1:0] data);
        cmd_valid = v;
        cmd_op    = op;
        cmd_count = cnt;
        load_data = data;
    endtask

    // Push the expectation for the next edge, advance, then pop and compare.
    task automatic edge_check(input logic [WIDTH-1:0] eq, input logic eb, input logic ed,
                              input string tag);
        exp_t e;
        exp_t p;
        logic [4:0] flags_obs;
        logic [4:0] flags_exp;
        e.q = eq; e.busy = eb; e.done = ed; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        checks++;
        assert (q === p.q) else begin
            errors++;
            $error("FAIL %s_q: observed=%h expected=%h", p.tag, q, p.q);
        end
        flags_obs = {busy, done, cmd_ready, serial_out_msb, serial_out_lsb};
        flags_exp = {p.busy, p.done, ~p.busy, p.q[WIDTH-1], p.q[0]};
        checks++;
        assert (flags_obs === flags_exp) else begin
            errors++;
            $error("FAIL %s_flags(busy,done,ready,msb,lsb): observed=%b expected=%b",
                   p.tag, flags_obs, flags_exp);
        end
    endtask

    logic [WIDTH-1:0] ror_seq [8];
    logic [WIDTH-1:0] shr_seq [4];

    initial begin
        ror_seq = '{8'h4B, 8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D, 8'h96};
        shr_seq = '{8'h7F, 8'h3F, 8'h1F, 8'h0F};

        // Reset held during a pending command
        rst = 1'b0; serial_in_left = 1'b0; serial_in_right = 1'b0;
        drive(1'b1, OP_LOAD, 4'd0, 8'h77);
        edge_check(8'h00, 1'b0, 1'b0, "reset0");
        edge_check(8'h00, 1'b0, 1'b0, "reset1");
        rst = 1'b1;
        drive(1'b0, OP_LOAD, 4'd0, 8'h00);
        edge_check(8'h00, 1'b0, 1'b0, "post_reset");

        // LOAD 0xA5
        drive(1'b1, OP_LOAD, 4'd0, 8'hA5);
        edge_check(8'hA5, 1'b0, 1'b1, "load_a5");
        drive(1'b0, OP_LOAD, 4'd0, 8'h00);
        edge_check(8'hA5, 1'b0, 1'b0, "load_a5_idle");

        // SHL x3 with serial_in_left=1, then back-to-back SHL x0
        serial_in_left = 1'b1;
        drive(1'b1, OP_SHL, 4'd3, 8'h00);
        edge_check(8'h4B, 1'b1, 1'b0, "shl3_s1");
        drive(1'b0, OP_SHL, 4'd0, 8'h00);
        edge_check(8'h97, 1'b1, 1'b0, "shl3_s2");
        edge_check(8'h2F, 1'b0, 1'b1, "shl3_s3");
        drive(1'b1, OP_SHL, 4'd0, 8'h00);
        edge_check(8'h2F, 1'b0, 1'b1, "shl0");
        drive(1'b0, OP_SHL, 4'd0, 8'h00);
        edge_check(8'h2F, 1'b0, 1'b0, "shl0_idle");

        // ROR by full width returns the original value
        drive(1'b1, OP_LOAD, 4'd0, 8'h96);
        edge_check(8'h96, 1'b0, 1'b1, "load_96");
        drive(1'b1, OP_ROR, 4'd8, 8'h00);
        for (int i = 0; i < 8; i++) begin
            edge_check(ror_seq[i], (i != 7), (i == 7), $sformatf("ror8_s%0d", i + 1));
            drive(1'b0, OP_ROR, 4'd0, 8'h00);
        end

        // ROL x1 never raises busy
        drive(1'b1, OP_LOAD, 4'd0, 8'h81);
        edge_check(8'h81, 1'b0, 1'b1, "load_81");
        drive(1'b1, OP_ROL, 4'd1, 8'h00);
        edge_check(8'h03, 1'b0, 1'b1, "rol1");
        drive(1'b0, OP_ROL, 4'd0, 8'h00);
        edge_check(8'h03, 1'b0, 1'b0, "rol1_idle");

        // ASR x2 ignores serial inputs and a LOAD offered while busy
        drive(1'b1, OP_LOAD, 4'd0, 8'h90);
        edge_check(8'h90, 1'b0, 1'b1, "load_90");
        serial_in_left = 1'b1; serial_in_right = 1'b1;
        drive(1'b1, OP_ASR, 4'd2, 8'h00);
        edge_check(8'hC8, 1'b1, 1'b0, "asr2_s1");
        serial_in_left = 1'b0; serial_in_right = 1'b0;
        drive(1'b1, OP_LOAD, 4'd0, 8'h11);
        edge_check(8'hE4, 1'b0, 1'b1, "asr2_s2");
        drive(1'b0, OP_LOAD, 4'd0, 8'h00);
        edge_check(8'hE4, 1'b0, 1'b0, "asr2_idle");

        // SHR x10 aborted by reset after four steps
        drive(1'b1, OP_LOAD, 4'd0, 8'hFF);
        edge_check(8'hFF, 1'b0, 1'b1, "load_ff");
        serial_in_right = 1'b0;
        drive(1'b1, OP_SHR, 4'd10, 8'h00);
        for (int i = 0; i < 4; i++) begin
            edge_check(shr_seq[i], 1'b1, 1'b0, $sformatf("shr10_s%0d", i + 1));
            drive(1'b0, OP_SHR, 4'd0, 8'h00);
        end
        rst = 1'b0;
        edge_check(8'h00, 1'b0, 1'b0, "abort_reset");
        rst = 1'b1;
        drive(1'b1, OP_LOAD, 4'd0, 8'h3C);
        edge_check(8'h3C, 1'b0, 1'b1, "load_3c");
        drive(1'b0, OP_LOAD, 4'd0, 8'h00);
        edge_check(8'h3C, 1'b0, 1'b0, "load_3c_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
